// File: rtl/unpack.sv
// unpack: serial line receiver. Hunts for a sync word, then slices the payload into
// output words, MSB-first, and delivers them through a small valid/ready FIFO.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_HUNT    | sliding the line through the sync register, waiting for a match
// S_PAYLOAD | locked; collecting payload bits into words and pushing them out
module unpack #(
  parameter int                       SIZE_BIT_PACK   = 1976,
  parameter int                       SIZE_PREAMBLE   = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE        = 32'h1ACF_FC1D,
  parameter int                       MAX_ERR         = 0,
  parameter int                       SIZE_OUTPUT_BIT = 8,
  parameter int                       FIFO_DEPTH      = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_data,
  input  logic                       i_valid,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_sop,
  output logic                       o_eop,
  output logic                       o_lock,
  output logic                       o_overflow
);

  localparam int PAYLOAD_BITS = SIZE_BIT_PACK - SIZE_PREAMBLE;
  localparam int W_BIT        = $clog2(PAYLOAD_BITS);
  localparam int W_FILL       = $clog2(SIZE_PREAMBLE + 1);
  localparam int W_SUB        = $clog2(SIZE_OUTPUT_BIT);
  localparam int W_PTR        = $clog2(FIFO_DEPTH);

  localparam logic [W_FILL-1:0] FILL_FULL  = W_FILL'(SIZE_PREAMBLE);
  localparam logic [W_FILL-1:0] MAX_ERR_W  = W_FILL'(MAX_ERR);
  localparam logic [W_BIT-1:0]  LAST_BIT   = W_BIT'(PAYLOAD_BITS - 1);
  localparam logic [W_BIT-1:0]  FIRST_DONE = W_BIT'(SIZE_OUTPUT_BIT - 1);
  localparam logic [W_SUB-1:0]  SUB_LAST   = W_SUB'(SIZE_OUTPUT_BIT - 1);

  typedef enum logic {S_HUNT, S_PAYLOAD} state_t;

  state_t r_state, w_state_next;

  // The oldest sync bit is only ever needed combinationally (it leaves on the
  // next shift), so the register keeps SIZE_PREAMBLE-1 bits.
  logic [SIZE_PREAMBLE-2:0]   r_shreg;
  logic [W_FILL-1:0]          r_fill;
  logic [SIZE_OUTPUT_BIT-2:0] r_word;
  logic [W_BIT-1:0]           r_bit_cnt;

  logic [SIZE_PREAMBLE-1:0]   w_shreg_next;
  logic [SIZE_PREAMBLE-1:0]   w_diff;
  logic [W_FILL-1:0]          w_fill_next;
  logic [W_FILL-1:0]          w_err_cnt;
  logic [SIZE_OUTPUT_BIT-1:0] w_word;
  logic w_hunt_bit, w_pay_bit, w_match, w_last_bit, w_word_done, w_sop, w_eop;

  logic [SIZE_OUTPUT_BIT-1:0] r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]      r_mem_sop, r_mem_eop;
  logic [W_PTR:0]             r_wr_ptr, r_rd_ptr;
  logic                       r_overflow;
  logic w_empty, w_full, w_pop, w_push, w_drop;

  assign w_hunt_bit   = i_valid && (r_state == S_HUNT);
  assign w_pay_bit    = i_valid && (r_state == S_PAYLOAD);
  assign w_shreg_next = {r_shreg, i_data};
  assign w_fill_next  = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
  assign w_diff       = w_shreg_next ^ PREAMBLE;

  // Hamming distance between the candidate window and the sync word.
  always_comb begin
    w_err_cnt = '0;
    for (int i = 0; i < SIZE_PREAMBLE; i++) w_err_cnt = w_err_cnt + W_FILL'(w_diff[i]);
  end

  assign w_match     = w_hunt_bit && (w_fill_next == FILL_FULL) && (w_err_cnt <= MAX_ERR_W);
  assign w_last_bit  = w_pay_bit && (r_bit_cnt == LAST_BIT);
  assign w_word_done = w_pay_bit && (r_bit_cnt[W_SUB-1:0] == SUB_LAST);
  assign w_word      = {r_word, i_data};
  assign w_sop       = (r_bit_cnt == FIRST_DONE);
  assign w_eop       = (r_bit_cnt == LAST_BIT);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_HUNT;
    else         r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HUNT:    if (w_match)    w_state_next = S_PAYLOAD;
      S_PAYLOAD: if (w_last_bit) w_state_next = S_HUNT;
      default:   w_state_next = S_HUNT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_lock = (r_state == S_PAYLOAD);
  end

  // Sync search register; wiped at packet end so the next hunt starts from scratch.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shreg <= '0;
      r_fill  <= '0;
    end else if (w_last_bit) begin
      r_shreg <= '0;
      r_fill  <= '0;
    end else if (w_hunt_bit) begin
      r_shreg <= w_shreg_next[SIZE_PREAMBLE-2:0];
      r_fill  <= w_fill_next;
    end
  end

  // Payload word assembly and bit position within the packet.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_word    <= '0;
      r_bit_cnt <= '0;
    end else if (w_pay_bit) begin
      r_word    <= w_word[SIZE_OUTPUT_BIT-2:0];
      r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[W_PTR] != r_rd_ptr[W_PTR]) &&
                   (r_wr_ptr[W_PTR-1:0] == r_rd_ptr[W_PTR-1:0]);
  assign w_pop   = !w_empty && i_ready;
  assign w_push  = w_word_done && (!w_full || w_pop);
  assign w_drop  = w_word_done && w_full && !w_pop;

  // Output FIFO storage and pointers; a pop frees a slot for a same-edge push.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem_data[i] <= '0;
      r_mem_sop  <= '0;
      r_mem_eop  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr[W_PTR-1:0]] <= w_word;
        r_mem_sop[r_wr_ptr[W_PTR-1:0]]  <= w_sop;
        r_mem_eop[r_wr_ptr[W_PTR-1:0]]  <= w_eop;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_overflow <= w_drop;
    end
  end

  // Head-of-FIFO presentation, forced to zero when empty.
  always_comb begin
    o_valid    = !w_empty;
    o_data     = w_empty ? '0 : r_mem_data[r_rd_ptr[W_PTR-1:0]];
    o_sop      = !w_empty && r_mem_sop[r_rd_ptr[W_PTR-1:0]];
    o_eop      = !w_empty && r_mem_eop[r_rd_ptr[W_PTR-1:0]];
    o_overflow = r_overflow;
  end

endmodule

// File: tb/tb_unpack.sv
module tb_unpack;
  localparam logic [31:0] PRE    = 32'h1ACF_FC1D;
  localparam int          PBITS  = 1944;
  localparam int          PBYTES = 243;

  logic       i_clk = 1'b0;
  logic       i_reset, i_data, i_valid, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_sop, o_eop, o_lock, o_overflow;

  unpack #(
    .SIZE_BIT_PACK(1976), .SIZE_PREAMBLE(32), .PREAMBLE(PRE),
    .MAX_ERR(1), .SIZE_OUTPUT_BIT(8), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_sop(o_sop),
    .o_eop(o_eop), .o_lock(o_lock), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  logic [9:0] exp_q[$];   // {sop, eop, data}
  logic [9:0] e;
  int n_checks = 0;
  int n_pass   = 0;
  int n_ovf    = 0;
  bit lock_seen = 0;
  bit tog = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
  endtask

  // Scoreboard monitor: compares every accepted output word against the queue head.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_overflow) n_ovf++;
      if (o_lock) lock_seen = 1;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output got=%0h sop=%0b eop=%0b expected none at %0t",
                   o_data, o_sop, o_eop, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_word", {22'b0, o_sop, o_eop, o_data}, {22'b0, e});
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    if (tog) begin
      i_valid = 1'b0;
      i_data  = 1'($urandom_range(0, 1));
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b0);
  endtask

  task automatic send_preamble(input logic [31:0] flip);
    logic [31:0] w;
    w = PRE ^ flip;
    for (int i = 31; i >= 0; i--) drive_bit(w[i]);
  endtask

  task automatic send_payload(input int drop_lo, input int drop_hi, input int ready_on, input int rst_at);
    for (int b = 0; b < PBITS; b++) begin
      int k;
      logic [7:0] kb;
      k  = b / 8;
      kb = 8'(k);
      if (b == ready_on) i_ready = 1'b1;
      if (b == rst_at) begin
        i_valid = 1'b0;
        i_reset = 1'b1;
        #2;
        check("rst_mid_valid", {31'b0, o_valid}, 0);
        check("rst_mid_data", {24'b0, o_data}, 0);
        check("rst_mid_sopeop", {30'b0, o_sop, o_eop}, 0);
        check("rst_mid_lock", {31'b0, o_lock}, 0);
        check("rst_mid_ovf", {31'b0, o_overflow}, 0);
        check("rst_mid_pending", exp_q.size(), 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        return;
      end
      if ((b % 8 == 7) && !(k >= drop_lo && k <= drop_hi))
        exp_q.push_back({(k == 0), (k == PBYTES - 1), kb});
      if (b == PBITS - 1) check("lock_before_end", {31'b0, o_lock}, 1);
      drive_bit(kb[7 - (b % 8)]);
    end
    check("lock_after_end", {31'b0, o_lock}, 0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge i_clk);
    #1;
    check(name, exp_q.size(), 0);
    check({name, "_valid_low"}, {31'b0, o_valid}, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_data = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", {19'b0, o_data, o_valid, o_sop, o_eop, o_lock, o_overflow}, 0);
    i_reset = 1'b0;

    // 1: clean packet
    send_idle(16);
    send_preamble(32'h0);
    send_payload(-1, -1, -1, -1);
    wait_drain("s1_drain");

    // 2: blank packet then real packet
    lock_seen = 0;
    send_idle(1976);
    check("s2_blank_no_lock", {31'b0, lock_seen}, 0);
    send_idle(8);
    send_preamble(32'h0);
    send_payload(-1, -1, -1, -1);
    wait_drain("s2_drain");

    // 3: tolerated and rejected sync errors
    send_idle(8);
    send_preamble(32'h0000_0100);
    check("s3_lock_1flip", {31'b0, o_lock}, 1);
    send_payload(-1, -1, -1, -1);
    wait_drain("s3_drain");
    lock_seen = 0;
    send_preamble(32'h8000_0001);
    send_idle(64);
    check("s3_nolock_2flip", {31'b0, lock_seen}, 0);

    // 4: backpressure: words 4..6 overflow, ready returns during word 7
    send_idle(8);
    i_ready = 1'b0;
    send_preamble(32'h0);
    send_payload(4, 6, 60, -1);
    wait_drain("s4_drain");
    check("s4_overflow_count", n_ovf, 3);

    // 5: half-rate line
    tog = 1;
    send_idle(8);
    send_preamble(32'h0);
    send_payload(-1, -1, -1, -1);
    wait_drain("s5_drain");
    tog = 0;

    // 6: reset mid-payload, then a clean packet
    send_idle(8);
    send_preamble(32'h0);
    send_payload(-1, -1, -1, 100);
    send_idle(16);
    send_preamble(32'h0);
    send_payload(-1, -1, -1, -1);
    wait_drain("s6_drain");
    check("total_overflow_count", n_ovf, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
